pmem_line_responder: RTL and testbench
======================================

# pmem_line_responder

Synthesizable physical-memory responder for the cache-line side of the L1 cache: answers `pmem_read`/`pmem_write` with 256-bit line transfers after a programmable latency. Backed by a small on-chip line array. Serves as the memory end of the cache hierarchy in simulation and FPGA builds, and as the template for the future L2 responder port.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`; must be at least 2, checked at elaboration.
- `IDX_W`, 6: line-index bits; the array holds 2^IDX_W lines.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_address`  in  32  byte address; bits [4:0] ignored, bits [5+:IDX_W] select the line, upper bits ignored (aliasing).
- `pmem_wdata`  in  256  full line to write.
- `pmem_read`  in  1  read request, held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  write request, held by the initiator until `pmem_resp`.
- `pmem_rdata`  out  256  line read data; valid in the `pmem_resp` cycle.
- `pmem_resp`  out  1  single-cycle completion pulse.
- `pmem_err`  out  1  sticky protocol-error flag.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - BUSY: count down the latency.
  - RESP: drive `pmem_resp` high for one cycle.
- IDLE, at an edge with `pmem_read | pmem_write`:
  - Latch the address, `pmem_wdata`, and op into internal registers.
  - Load `cnt = LATENCY-2`, go to BUSY.
- BUSY, at each edge:
  - If `cnt == 0`: perform the access and go to RESP.
  - Otherwise decrement `cnt`.
- Access:
  - Write: stores the latched wdata into `array[idx]`.
  - Read: loads `array[idx]` into the `pmem_rdata` register.
- RESP: `pmem_resp = 1` (decoded from state). At the next edge go to IDLE unconditionally.
- Back-to-back requests (writeback then fill): IDLE may accept a new request at the edge immediately after the RESP cycle.
- Read and write both high at acceptance: treated as a write; `pmem_err` is set.
- Request input changes during BUSY/RESP: ignored, because the latched copies are used.
- `pmem_err` is also set if a request drops during BUSY. It clears only on reset.
- `pmem_rdata` holds its last value outside RESP. It is not updated by writes.
- Array contents are not reset; reads of never-written lines return X in simulation.

## Timing
- Reset values: state IDLE, `cnt` 0, `pmem_resp` 0, `pmem_rdata` 0, `pmem_err` 0, latched registers 0.
- Request accepted at edge E0. `pmem_resp` is high during the cycle following edge E0+LATENCY-1, i.e. exactly LATENCY cycles after E0.
- Throughput: one transfer per LATENCY+1 cycles.
- Reset during BUSY: the transaction is discarded and no write is performed. Reset during RESP: `pmem_resp` drops immediately (asynchronous); an already-performed write remains.
- A write is visible to any read accepted after its RESP cycle.

## Structure
- Types from the shared `rv32i_types` package:
  - `rv32i_word` for the address.
  - `rv32i_cache_line` for `pmem_wdata`/`pmem_rdata`.
- Additions to `rv32i_types`:
  - State enum `pmem_resp_state_t` {IDLE, BUSY, RESP}.
  - Constant `LINE_OFFSET_W = 5`.
- One sub-module, `pmem_line_array`:
  - 2^IDX_W × 256 synchronous array.
  - Ports: `we`, `re`, `idx`, `din`, `dout`.
  - No reset.
- Top level holds the FSM, counter, latches, and error flag.

## Test plan
- Reset with `rst_n=0`, request lines asserted → `pmem_resp` 0, `pmem_rdata` 0, `pmem_err` 0; FSM stays IDLE until release.
- Write 0xA5 pattern to 0x0000_0040, then read 0x0000_0040 (LATENCY=4) → each `pmem_resp` arrives exactly 4 cycles after acceptance; read returns the pattern.
- Write to 0x0000_0800 with IDX_W=6, then read 0x0000_0000 → aliasing returns the written line. Then write 0x1F-offset address 0x0000_005F and read 0x0000_0040 → same line.
- Writeback at 0x100 immediately followed by fill read at 0x200 (L1 miss sequence) → two resp pulses 5 cycles apart; read data correct; no err.
- `pmem_read` and `pmem_write` both high at 0x80 → write performed, `pmem_err`=1 and stays 1 through later clean transactions.
- `rst_n` pulsed low mid-BUSY of a write to 0xC0 → no resp; a subsequent read of 0xC0 returns the old contents.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types plus the line responder state enum and offset width
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] rv32i_cache_line;

    // Byte-offset bits within a 32-byte cache line.
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_resp_state_t;

endpackage

// File: rtl/pmem_line_responder_if.sv
// rtl/pmem_line_responder_if.sv - cache-line physical-memory bus between the L1 cache and its responder
//   master (cache side): drives pmem_address, pmem_wdata, pmem_read, pmem_write;
//                        receives pmem_rdata, pmem_resp, pmem_err
//   slave (memory side): the reverse
interface pmem_line_responder_if;
    import rv32i_types::*;

    rv32i_word       pmem_address;
    rv32i_cache_line pmem_wdata;
    logic            pmem_read;
    logic            pmem_write;
    rv32i_cache_line pmem_rdata;
    logic            pmem_resp;
    logic            pmem_err;

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp, pmem_err
    );

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp, pmem_err
    );
endinterface

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - 2^IDX_W x 256-bit line store, synchronous write, gated combinational read, no reset
//   clk  : clock
//   we   : write din into line idx at the rising edge
//   re   : present line idx on dout (dout is zero otherwise)
//   idx  : line index
//   din  : line to write
//   dout : line read
module pmem_line_array
    import rv32i_types::*;
#(
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [IDX_W-1:0]   idx,
    input  rv32i_cache_line    din,
    output rv32i_cache_line    dout
);

    localparam int DEPTH = 1 << IDX_W;

    rv32i_cache_line mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    // The responder registers this value itself, so the read path stays combinational.
    assign dout = re ? mem[idx] : '0;

endmodule

// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - physical-memory responder answering 256-bit line reads/writes after LATENCY cycles
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pmem_line_responder_if
//           (pmem_address/pmem_wdata/pmem_read/pmem_write in; pmem_rdata/pmem_resp/pmem_err out)
module pmem_line_responder
    import rv32i_types::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_line_responder_if.slave bus
);

    generate
        if (LATENCY < 2) begin : g_latency_check
            $error("pmem_line_responder: LATENCY must be at least 2");
        end
    endgenerate

    // Counter only ever holds values up to LATENCY-2.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    pmem_resp_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [IDX_W-1:0] idx_q;
    rv32i_cache_line  wdata_q;
    logic             op_write_q;
    rv32i_cache_line  rdata_q;
    logic             err_q;

    logic             capture;
    logic             do_access;
    logic             err_set;
    logic             req_any;
    logic             arr_we;
    logic             arr_re;
    rv32i_cache_line  arr_dout;

    assign req_any = bus.pmem_read | bus.pmem_write;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        capture   = 1'b0;
        do_access = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    capture = 1'b1;
                    cnt_n   = CNT_LOAD;
                    state_n = BUSY;
                    // Conflicting request: served as a write, but flagged.
                    if (bus.pmem_read && bus.pmem_write) begin
                        err_set = 1'b1;
                    end
                end
            end
            BUSY: begin
                // The initiator must hold its request until the response.
                if (!req_any) begin
                    err_set = 1'b1;
                end
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_n   = RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                idx_q      <= bus.pmem_address[LINE_OFFSET_W +: IDX_W];
                wdata_q    <= bus.pmem_wdata;
                op_write_q <= bus.pmem_write;
            end
            if (arr_re) begin
                rdata_q <= arr_dout;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Accesses use only the latched copies, so request changes after acceptance are harmless.
    assign arr_we = do_access & op_write_q;
    assign arr_re = do_access & ~op_write_q;

    pmem_line_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (idx_q),
        .din  (wdata_q),
        .dout (arr_dout)
    );

    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_resp  = (state == RESP);
    assign bus.pmem_err   = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb/tb_pmem_line_responder.sv - directed self-checking bench for pmem_line_responder
module tb_pmem_line_responder;
    import rv32i_types::*;

    localparam int LATENCY = 4;
    localparam int IDX_W   = 6;
    localparam int TIMEOUT = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pmem_line_responder_if bus ();

    pmem_line_responder #(
        .LATENCY (LATENCY),
        .IDX_W   (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input rv32i_word a, input rv32i_cache_line w, input logic rd, input logic wr);
        bus.pmem_address = a;
        bus.pmem_wdata   = w;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
    endtask

    task automatic drop();
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    // Counts falling edges from the current one until pmem_resp is seen (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.pmem_resp !== 1'b1 && lat < TIMEOUT);
    endtask

    task automatic xfer(input string tag, input rv32i_word a, input rv32i_cache_line w,
                        input logic rd, input logic wr, output rv32i_cache_line rdata);
        int lat;
        @(negedge clk);
        req(a, w, rd, wr);
        wait_resp(lat);
        check({tag, "_latency"}, 256'(lat), 256'(LATENCY));
        rdata = bus.pmem_rdata;
        drop();
    endtask

    initial begin
        rv32i_cache_line p_a5, p2, p3, p4, p5, p6, p7, p8, rd;
        int lat1, lat2;
        checks = 0;
        errors = 0;
        p_a5 = {32{8'hA5}};
        p2   = {8{32'h1234_5678}};
        p3   = {8{32'hDEAD_BEEF}};
        p4   = {8{32'h0BAD_F00D}};
        p5   = {8{32'hCAFE_0123}};
        p6   = {8{32'h5555_AAAA}};
        p7   = {8{32'h0F0F_7777}};
        p8   = {8{32'hFFFF_0000}};

        // Reset held with both request lines asserted.
        rst_n = 1'b0;
        req(32'h0000_0040, p_a5, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_resp", 256'(bus.pmem_resp), 256'(0));
        check("rst_rdata", bus.pmem_rdata, 256'(0));
        check("rst_err", 256'(bus.pmem_err), 256'(0));
        drop();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_resp", 256'(bus.pmem_resp), 256'(0));

        // Basic write then read.
        xfer("wr40", 32'h0000_0040, p_a5, 1'b0, 1'b1, rd);
        xfer("rd40", 32'h0000_0040, '0, 1'b1, 1'b0, rd);
        check("rd40_data", rd, p_a5);
        check("basic_err", 256'(bus.pmem_err), 256'(0));

        // Index aliasing and ignored byte offset.
        xfer("wr800", 32'h0000_0800, p2, 1'b0, 1'b1, rd);
        xfer("rd000", 32'h0000_0000, '0, 1'b1, 1'b0, rd);
        check("alias_data", rd, p2);
        xfer("wr05f", 32'h0000_005F, p3, 1'b0, 1'b1, rd);
        xfer("rd040", 32'h0000_0040, '0, 1'b1, 1'b0, rd);
        check("offset_data", rd, p3);

        // Writeback to 0x100 immediately followed by fill from 0x200.
        xfer("wr200", 32'h0000_0200, p5, 1'b0, 1'b1, rd);
        @(negedge clk);
        req(32'h0000_0100, p4, 1'b0, 1'b1);
        wait_resp(lat1);
        check("wb_latency", 256'(lat1), 256'(LATENCY));
        req(32'h0000_0200, '0, 1'b1, 1'b0);
        wait_resp(lat2);
        check("b2b_spacing", 256'(lat2), 256'(LATENCY + 1));
        check("fill_data", bus.pmem_rdata, p5);
        drop();
        check("b2b_err", 256'(bus.pmem_err), 256'(0));
        xfer("rd100", 32'h0000_0100, '0, 1'b1, 1'b0, rd);
        check("wb_data", rd, p4);

        // Read and write both asserted: served as a write, error sticks.
        xfer("both80", 32'h0000_0080, p6, 1'b1, 1'b1, rd);
        check("both_err", 256'(bus.pmem_err), 256'(1));
        xfer("rd80", 32'h0000_0080, '0, 1'b1, 1'b0, rd);
        check("both_data", rd, p6);
        check("err_sticky", 256'(bus.pmem_err), 256'(1));

        // Reset in the middle of a write's BUSY phase discards it.
        xfer("wrc0", 32'h0000_00C0, p7, 1'b0, 1'b1, rd);
        @(negedge clk);
        req(32'h0000_00C0, p8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        drop();
        #1;
        check("midrst_resp", 256'(bus.pmem_resp), 256'(0));
        check("midrst_err", 256'(bus.pmem_err), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LATENCY + 2) begin
            @(negedge clk);
            check("no_resp_after_rst", 256'(bus.pmem_resp), 256'(0));
        end
        xfer("rdc0", 32'h0000_00C0, '0, 1'b1, 1'b0, rd);
        check("rst_discard_data", rd, p7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
